// File: rtl/mult_32x32_pkg.sv
// Shared definitions for the sequential 32x32 multiplier.
//   state_e      : controller states (IDLE plus eight compute states)
//   a_sel_t      : selects byte i of the multiplicand
//   b_sel_t      : selects 16-bit half j of the multiplier
//   shift_sel_t  : partial-product shift in units of 8 bits
// Compute states are encoded as {1'b1, b_sel, a_sel} so the selects are
// plain bit fields of the state register.
package mult32x32_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0000,
    ST_A0B0 = 4'b1000,
    ST_A1B0 = 4'b1001,
    ST_A2B0 = 4'b1010,
    ST_A3B0 = 4'b1011,
    ST_A0B1 = 4'b1100,
    ST_A1B1 = 4'b1101,
    ST_A2B1 = 4'b1110,
    ST_A3B1 = 4'b1111
  } state_e;

  typedef logic [1:0] a_sel_t;
  typedef logic       b_sel_t;
  typedef logic [2:0] shift_sel_t;

  // Byte i of a and half j of b land at bit 8*i + 16*j, i.e. 8*(i + 2*j).
  function automatic shift_sel_t shift_sel_of(input a_sel_t a_sel,
                                              input b_sel_t b_sel);
    return {1'b0, a_sel} + {1'b0, b_sel, 1'b0};
  endfunction

endpackage

// File: rtl/mult_32x32_mult16x8.sv
// Combinational unsigned 16x8 -> 24-bit multiplier.
//   a_i : 16-bit unsigned operand
//   b_i : 8-bit unsigned operand
//   p_o : 24-bit unsigned product
module mult16x8 (
  input  logic [15:0] a_i,
  input  logic [7:0]  b_i,
  output logic [23:0] p_o
);

  assign p_o = {8'd0, a_i} * {16'd0, b_i};

endmodule

// File: rtl/mult_32x32.sv
// Sequential unsigned 32x32 -> 64-bit multiplier. One 16x8 partial product
// is accumulated per cycle; a result takes 8 cycles after start is accepted.
//   clk     : rising-edge clock
//   reset   : asynchronous, active-low reset
//   start   : single-cycle request, accepted only while idle
//   a, b    : unsigned operands, sampled with an accepted start
//   busy    : high while a multiplication is in progress
//   product : registered result, final when busy is low
module mult_32x32
  import mult32x32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [63:0] product
);

  state_e      state_q, state_d;
  logic        clr_prod, upd_prod;
  a_sel_t      a_sel;
  b_sel_t      b_sel;
  shift_sel_t  shift_sel;

  logic [31:0] a_q, b_q;
  logic [63:0] prod_q, prod_d;
  logic [7:0]  a_byte;
  logic [15:0] b_half;
  logic [23:0] pp;
  logic [63:0] pp_shifted;

  // Controller
  always_comb begin
    state_d  = state_q;
    clr_prod = 1'b0;
    upd_prod = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_A0B0;
          clr_prod = 1'b1;
        end
      end
      ST_A0B0: begin state_d = ST_A1B0; upd_prod = 1'b1; end
      ST_A1B0: begin state_d = ST_A2B0; upd_prod = 1'b1; end
      ST_A2B0: begin state_d = ST_A3B0; upd_prod = 1'b1; end
      ST_A3B0: begin state_d = ST_A0B1; upd_prod = 1'b1; end
      ST_A0B1: begin state_d = ST_A1B1; upd_prod = 1'b1; end
      ST_A1B1: begin state_d = ST_A2B1; upd_prod = 1'b1; end
      ST_A2B1: begin state_d = ST_A3B1; upd_prod = 1'b1; end
      ST_A3B1: begin state_d = ST_IDLE; upd_prod = 1'b1; end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign a_sel     = state_q[1:0];
  assign b_sel     = state_q[2];
  assign shift_sel = shift_sel_of(a_sel, b_sel);
  assign busy      = (state_q != ST_IDLE);

  // Datapath: operand select, partial product, shift and accumulate
  always_comb begin
    a_byte = 8'd0;
    case (a_sel)
      2'd0: a_byte = a_q[7:0];
      2'd1: a_byte = a_q[15:8];
      2'd2: a_byte = a_q[23:16];
      2'd3: a_byte = a_q[31:24];
      default: a_byte = 8'd0;
    endcase
  end

  assign b_half = b_sel ? b_q[31:16] : b_q[15:0];

  mult16x8 u_mult16x8 (
    .a_i (b_half),
    .b_i (a_byte),
    .p_o (pp)
  );

  assign pp_shifted = {40'd0, pp} << {shift_sel, 3'b000};

  always_comb begin
    prod_d = prod_q;
    if (clr_prod)      prod_d = 64'd0;
    else if (upd_prod) prod_d = prod_q + pp_shifted;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      prod_q <= 64'd0;
    end else begin
      if (clr_prod) begin
        a_q <= a;
        b_q <= b;
      end
      prod_q <= prod_d;
    end
  end

  assign product = prod_q;

endmodule

// File: tb/tb_mult_32x32.sv
module tb_mult_32x32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [63:0] product;

  int tests_run;
  int tests_failed;

  logic [63:0] exp_q[$];

  mult_32x32 dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, got, exp);
    end
  endtask

  // Monitor: counts busy cycles and compares product when busy falls.
  logic busy_prev;
  int   busy_cnt;
  initial begin
    busy_prev = 1'b0;
    busy_cnt  = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_prev = 1'b0;
        busy_cnt  = 0;
      end else begin
        if (busy) begin
          busy_cnt++;
          if (busy_cnt == 1) check("product_zero_first_cycle", product, 64'd0);
        end else if (busy_prev) begin
          check("busy_cycles", 64'(busy_cnt), 64'd8);
          if (exp_q.size() == 0) begin
            check("unexpected_result", 64'd1, 64'd0);
          end else begin
            check("product", product, exp_q.pop_front());
          end
          busy_cnt = 0;
        end
        busy_prev = busy;
      end
    end
  end

  // Wait (bounded) for idle, then issue one start and queue its result.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] exp);
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check("idle_timeout", 64'd1, 64'd0);
    exp_q.push_back(exp);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b0;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;

    // Reset held for 2 cycles, then released.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_product", product, 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_reset_busy", 64'(busy), 64'd0);
      check("post_reset_product", product, 64'd0);
    end
    @(posedge clk); #1;

    issue(32'h0C46B736, 32'h1302BF7F, 64'h00E961554A322DCA);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    issue(32'h00000000, 32'h12345678, 64'h0000000000000000);
    issue(32'h00000001, 32'hDEADBEEF, 64'h00000000DEADBEEF);
    issue(32'h000000FF, 32'h0000FFFF, 64'h0000000000FEFF01);
    issue(32'h01000000, 32'h00010000, 64'h0000010000000000);
    issue(32'h80000000, 32'h80000000, 64'h4000000000000000);
    issue(32'h00000002, 32'h80000000, 64'h0000000100000000);

    // Re-pulse start with new operands mid-operation: must be ignored.
    issue(32'h0C46B736, 32'h1302BF7F, 64'h00E961554A322DCA);
    cycles(2);
    a = 32'hFFFFFFFF;
    b = 32'hFFFFFFFF;
    start = 1'b1;
    cycles(1);
    start = 1'b0;

    // Abort an operation with reset at its fourth compute cycle.
    while (busy) cycles(1);
    a = 32'hFFFFFFFF;
    b = 32'hFFFFFFFF;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(3);
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_product", product, 64'd0);
    cycles(1);
    reset = 1'b1;
    cycles(1);
    issue(32'h00000001, 32'hDEADBEEF, 64'h00000000DEADBEEF);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cycles(1);
    cycles(2);
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
